// File: rtl/maxpool_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_cfg_sequencer : AXI4-Lite master that writes, verifies and starts   |
// | the maxpool engine, then polls its done bit. Option: MAXPOOL_SEQ_POLL_TIMEOUT_EN |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module maxpool_cfg_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h4000_0000),
  parameter int                    NUM_REGS    = 4,
  parameter logic [DATA_WIDTH-1:0] DATA_SEED   = DATA_WIDTH'(32'hA5A5_0000),
  parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET = ADDR_WIDTH'(32'h40),
  parameter logic [ADDR_WIDTH-1:0] STAT_OFFSET = ADDR_WIDTH'(32'h44),
  parameter int                    POLL_LIMIT  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    INIT_AXI_TXN,
  output logic                    TXN_DONE,
  output logic                    ERROR,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int                    IDX_W     = $clog2(NUM_REGS) + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = BASE_ADDR + CTRL_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = BASE_ADDR + STAT_OFFSET;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_GO   = 3'd3;
  localparam logic [2:0] S_POLL = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [1:0]            init_sync_q, init_sync_d;
  logic                  start_q, start_d;
  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  error_q, error_d;
  logic                  txn_done_q, txn_done_d;

  logic                  b_hs;
  logic                  r_hs;
  logic [IDX_W-1:0]      idx_inc;

`ifdef MAXPOOL_SEQ_POLL_TIMEOUT_EN
  localparam int            PC_W    = $clog2(POLL_LIMIT + 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_LIMIT - 1);
  logic [PC_W-1:0]          poll_cnt_q, poll_cnt_d;
`else
  logic                     unused_poll_limit;
  assign unused_poll_limit = ^POLL_LIMIT;
`endif

  function automatic logic [ADDR_WIDTH-1:0] cfg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + (ADDR_WIDTH'(i) << 2);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cfg_data(input logic [IDX_W-1:0] i);
    return DATA_SEED + DATA_WIDTH'(i);
  endfunction

  assign b_hs    = BVALID & bready_q;
  assign r_hs    = RVALID & rready_q;
  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    init_sync_d = {init_sync_q[0], INIT_AXI_TXN};
    start_d     = init_sync_q[0] & ~init_sync_q[1];
    state_d     = state_q;
    idx_d       = idx_q;
    // Each channel lowers its own VALID/READY once its handshake completes.
    awvalid_d   = awvalid_q & ~AWREADY;
    wvalid_d    = wvalid_q & ~WREADY;
    bready_d    = bready_q & ~BVALID;
    arvalid_d   = arvalid_q & ~ARREADY;
    rready_d    = rready_q & ~RVALID;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    error_d     = error_q;
    txn_done_d  = 1'b0;
`ifdef MAXPOOL_SEQ_POLL_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif

    if (b_hs && (BRESP != 2'b00)) error_d = 1'b1;
    if (r_hs && (RRESP != 2'b00)) error_d = 1'b1;

    // The next transaction is launched in the completion cycle of the last one.
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d   = S_WR;
          idx_d     = '0;
          error_d   = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          awaddr_d  = cfg_addr('0);
          wdata_d   = cfg_data('0);
        end
      end
      S_WR: begin
        if (b_hs) begin
          if (idx_q == LAST_IDX) begin
            state_d   = S_RD;
            idx_d     = '0;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = cfg_addr('0);
          end else begin
            idx_d     = idx_inc;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            awaddr_d  = cfg_addr(idx_inc);
            wdata_d   = cfg_data(idx_inc);
          end
        end
      end
      S_RD: begin
        if (r_hs) begin
          if (RDATA != cfg_data(idx_q)) error_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = S_GO;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            awaddr_d  = CTRL_ADDR;
            wdata_d   = DATA_WIDTH'(1);
          end else begin
            idx_d     = idx_inc;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = cfg_addr(idx_inc);
          end
        end
      end
      S_GO: begin
        if (b_hs) begin
          state_d   = S_POLL;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          araddr_d  = STAT_ADDR;
`ifdef MAXPOOL_SEQ_POLL_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      S_POLL: begin
        if (r_hs) begin
          if (RDATA[0]) begin
            state_d    = S_DONE;
            txn_done_d = 1'b1;
          end else begin
`ifdef MAXPOOL_SEQ_POLL_TIMEOUT_EN
            if (poll_cnt_q == PC_LAST) begin
              state_d    = S_DONE;
              txn_done_d = 1'b1;
              error_d    = 1'b1;
            end else begin
              poll_cnt_d = poll_cnt_q + PC_W'(1);
              arvalid_d  = 1'b1;
              rready_d   = 1'b1;
            end
`else
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Edge detector resets to "high" so an INIT held across reset is not a start.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_sync_q <= 2'b11;
      start_q     <= 1'b0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      error_q     <= 1'b0;
      txn_done_q  <= 1'b0;
    end else begin
      init_sync_q <= init_sync_d;
      start_q     <= start_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      error_q     <= error_d;
      txn_done_q  <= txn_done_d;
    end
  end

`ifdef MAXPOOL_SEQ_POLL_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) poll_cnt_q <= '0;
    else          poll_cnt_q <= poll_cnt_d;
  end
`endif

  assign TXN_DONE = txn_done_q;
  assign ERROR    = error_q;
  assign AWADDR   = awaddr_q;
  assign AWPROT   = 3'b000;
  assign AWVALID  = awvalid_q;
  assign WDATA    = wdata_q;
  assign WSTRB    = '1;
  assign WVALID   = wvalid_q;
  assign BREADY   = bready_q;
  assign ARADDR   = araddr_q;
  assign ARPROT   = 3'b000;
  assign ARVALID  = arvalid_q;
  assign RREADY   = rready_q;

endmodule
`default_nettype wire

// File: doc/maxpool_cfg_sequencer.md
Name: maxpool_cfg_sequencer

Overview:
AXI4-Lite master sequencer that programs and launches the maxpool engine, then waits for it to finish. A rising edge on INIT_AXI_TXN starts four phases in order:
- write NUM_REGS config words;
- read them back and compare;
- write the start command;
- poll the status register until the done bit is set.
It reports TXN_DONE and ERROR to the system/testbench. It sits between the top-level init/done handshake and the engine's AXI4-Lite slave port.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width (32 only).
BASE_ADDR, 32'h4000_0000, engine register base.
NUM_REGS, 4, config registers at BASE_ADDR+4*i, i=0..NUM_REGS-1 (range 1..16).
DATA_SEED, 32'hA5A5_0000, config word i = DATA_SEED + i.
CTRL_OFFSET, 32'h40, start register offset; start command data = 32'h1.
STAT_OFFSET, 32'h44, status register offset; bit0 = engine done.
POLL_LIMIT, 1024, max status reads before timeout (timeout feature only).

Ports:
ACLK  in  1  clock.
ARESETN  in  1  async active-low reset.
INIT_AXI_TXN  in  1  start request; rising-edge sensitive.
TXN_DONE  out  1  high for one cycle at sequence end.
ERROR  out  1  sticky error flag.
AWADDR out ADDR_WIDTH; AWPROT out 3 (fixed 3'b000); AWVALID out 1; AWREADY in 1.
WDATA out 32; WSTRB out 4 (fixed 4'hF); WVALID out 1; WREADY in 1.
BRESP in 2; BVALID in 1; BREADY out 1.
ARADDR out ADDR_WIDTH; ARPROT out 3 (fixed 3'b000); ARVALID out 1; ARREADY in 1.
RDATA in 32; RRESP in 2; RVALID in 1; RREADY out 1.

Behaviour:
- Reset: everything asynchronous. All VALID/READY outputs, TXN_DONE, ERROR and counters are 0; address/data outputs are 0; state is IDLE.
- Start detection: INIT_AXI_TXN passes through a 2-flop register; a pulse is taken on 0->1. The FSM leaves IDLE 1 cycle after the pulse (3 ACLK after the pin edge).
- Write handshake:
  - AWVALID and WVALID are asserted in the same cycle.
  - Each drops independently in the cycle after its own handshake (VALID&READY).
  - BREADY is asserted from issue until BVALID is seen.
  - The next transaction issues only after the B handshake. At most one outstanding transaction.
- Read handshake: ARVALID is held until ARREADY; RREADY is asserted until RVALID. RDATA/RRESP are sampled when RVALID&RREADY.
- VALID signals never drop before their handshake; addr/data stay stable while VALID is high.
- States and transitions:
  - IDLE -> WR on start pulse. On entry to WR: clear ERROR, clear index.
  - WR: write config word i. After B, if i==NUM_REGS-1 go to RD with i=0, else i+1.
  - RD: read BASE_ADDR+4*i and compare RDATA against DATA_SEED+i. After the last read go to GO.
  - GO: single write of 32'h1 to BASE_ADDR+CTRL_OFFSET, then go to POLL.
  - POLL: repeated reads of BASE_ADDR+STAT_OFFSET, back-to-back with no idle cycles. Go to DONE when RDATA[0]==1.
  - DONE: pulse TXN_DONE for 1 cycle, then IDLE.
- ERROR (sticky until next start) is set by any of:
  - BRESP != 2'b00;
  - RRESP != 2'b00;
  - readback mismatch.
  On any error the sequence continues to completion; no early abort.
- INIT_AXI_TXN edges outside IDLE are ignored; they are not queued.
- ARESETN asserted mid-transaction: all VALIDs drop immediately and the FSM returns to IDLE. The slave is assumed to be reset by the same ARESETN.
- Index counter width is $clog2(NUM_REGS)+1. Address = BASE_ADDR + (i<<2), truncated to ADDR_WIDTH.

Optional Feature:
MAXPOOL_SEQ_POLL_TIMEOUT_EN
- Defined: a poll counter counts completed status reads in POLL. When it reaches POLL_LIMIT with bit0 still 0, set ERROR and go to DONE (TXN_DONE still pulses).
- Undefined: no counter; POLL waits indefinitely; POLL_LIMIT is unused.

Test Plan:
- Nominal: slave memory model (always ready, OKAY, done bit set on 3rd status read), INIT 0->1 -> 4 writes A5A5_0000..A5A5_0003 to 0x4000_0000..0x4000_000C, 4 matching reads, write 1 to 0x4000_0040, 3 reads of 0x4000_0044, TXN_DONE pulses once, ERROR=0.
- Backpressure: AWREADY delayed 3 cycles, WREADY delayed 0, random BVALID delay 0-5 -> AWVALID/WVALID drop independently, values stable while VALID, same final result, ERROR=0.
- Mismatch: model returns 0xDEAD_BEEF for reg 2 -> all remaining transactions still issued, TXN_DONE pulses, ERROR=1; a second INIT clears ERROR at start, and a clean run ends with ERROR=0.
- Response error: BRESP=2'b10 on GO write -> ERROR=1 at end; likewise RRESP=2'b11 on a readback.
- Reset mid-run: ARESETN low during 2nd write with AWVALID=1 -> all outputs 0 asynchronously; after release, INIT held high produces no start until it goes 0->1 again.
- Timeout (MAXPOOL_SEQ_POLL_TIMEOUT_EN, POLL_LIMIT=8): status bit0 never set -> exactly 8 status reads, ERROR=1, TXN_DONE pulse. Without the macro: still polling after 100 reads.
